// File: rtl/sd2_mod_normalize.sv
// Converts an N-digit signed-digit (sd2) ALU result to binary, then folds it into [0, m)
// by repeated add/subtract of the latched odd modulus, with a bounded number of corrections.
module sd2_mod_normalize #(
  parameter int N       = 8,
  parameter int DPC     = 2,
  parameter int MAX_FIX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][1:0]   z,
  input  logic [N-1:0]        m,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        r,
  output logic                err
);

  localparam int AW = N + 2;
  localparam int KW = $clog2(N + 1);
  localparam int FW = $clog2(MAX_FIX + 1);

  localparam logic [1:0] DIG_NEG = 2'b00;
  localparam logic [1:0] DIG_POS = 2'b10;
  localparam logic [1:0] DIG_BAD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [KW-1:0]          k_q, k_d;
  logic [FW-1:0]          fix_cnt_q, fix_cnt_d;
  logic [N-1:0][1:0]      z_q, z_d;
  logic [N-1:0]           m_q, m_d;
  logic                   bad_q, bad_d;
  logic [N-1:0]           r_q, r_d;
  logic                   err_q, err_d;

  logic signed [AW-1:0]   grp;
  logic                   grp_bad;
  logic signed [AW-1:0]   m_ext;

  assign m_ext     = signed'({2'b00, m_q});
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign r         = r_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    fix_cnt_d = fix_cnt_q;
    z_d       = z_q;
    m_d       = m_q;
    bad_d     = bad_q;
    r_d       = r_q;
    err_d     = err_q;

    // z_q is shifted down each CONV cycle, so its low DPC digits always carry weights 2^k..2^(k+DPC-1)
    grp     = '0;
    grp_bad = 1'b0;
    for (int j = 0; j < DPC; j++) begin
      case (z_q[j])
        DIG_NEG: grp = grp - (AW'(1) << j);
        DIG_POS: grp = grp + (AW'(1) << j);
        DIG_BAD: grp_bad = 1'b1;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          z_d       = z;
          m_d       = m;
          acc_d     = '0;
          k_d       = '0;
          fix_cnt_d = '0;
          bad_d     = 1'b0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        acc_d = acc_q + (grp <<< k_q);
        bad_d = bad_q | grp_bad;
        z_d   = z_q >> (2 * DPC);
        k_d   = k_q + KW'(DPC);
        if (k_q == KW'(N - DPC)) state_d = S_FIX;
      end
      S_FIX: begin
        if (acc_q < 0 || acc_q >= m_ext) begin
          if (fix_cnt_q == FW'(MAX_FIX)) begin
            err_d   = 1'b1;
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            acc_d     = (acc_q < 0) ? acc_q + m_ext : acc_q - m_ext;
            fix_cnt_d = fix_cnt_q + FW'(1);
          end
        end else begin
          r_d     = acc_q[N-1:0];
          err_d   = bad_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      k_q       <= '0;
      fix_cnt_q <= '0;
      z_q       <= '0;
      m_q       <= '0;
      bad_q     <= 1'b0;
      r_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      fix_cnt_q <= fix_cnt_d;
      z_q       <= z_d;
      m_q       <= m_d;
      bad_q     <= bad_d;
      r_q       <= r_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sd2_mod_normalize.sv
// Directed and random checks of sd2_mod_normalize against an arithmetic model of the
// digit value, the correction count and the resulting handshake latency.
module tb_sd2_mod_normalize;

  localparam int N       = 8;
  localparam int DPC     = 2;
  localparam int MAX_FIX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0][1:0] z;
  logic [N-1:0]      m;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      r;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;

  sd2_mod_normalize #(.N(N), .DPC(DPC), .MAX_FIX(MAX_FIX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .z(z), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Value = sum d_i*2^i, then fold into [0,mm) one add/subtract at a time
  task automatic model(input logic [2*N-1:0] zz, input int mm,
                       output int er, output int ee, output int el);
    int v, cnt, bad;
    logic [1:0] dg;
    v = 0; bad = 0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      dg = zz[2*i +: 2];
      if (dg == 2'b00) v -= (1 << i);
      else if (dg == 2'b10) v += (1 << i);
      else if (dg == 2'b11) bad = 1;
    end
    el = N / DPC + 1;
    forever begin
      if (v >= 0 && v < mm) begin
        er = v; ee = bad; break;
      end
      if (cnt == MAX_FIX) begin
        er = 0; ee = 1; break;
      end
      v = (v < 0) ? v + mm : v - mm;
      cnt++;
      el++;
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [2*N-1:0] zz, input logic [N-1:0] mm,
                                input int hold, input bit keep_valid);
    int er, ee, el, lat;
    bit seen;
    model(zz, int'(mm), er, ee, el);
    @(negedge clk);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; z = zz; m = mm;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    z = $urandom; m = $urandom;
    lat = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
      if (out_valid) begin seen = 1; break; end
    end
    in_valid = 1'b0;
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(el));
    check({tag, ".r"}, 32'(r), 32'(er));
    check({tag, ".err"}, 32'(err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_r"}, 32'(r), 32'(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".post_r"}, 32'(r), 32'(er));
  endtask

  initial begin
    logic [2*N-1:0] rz;
    logic [N-1:0]   rm;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; m = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.r", 32'(r), 32'd0);
    check("reset.err", 32'(err), 32'd0);

    apply_stimulus("t1", 16'h5558, 8'd11, 0, 1'b0);
    apply_stimulus("t2", 16'h0000, 8'd251, 0, 1'b0);
    apply_stimulus("t3", 16'h5554, 8'd11, 3, 1'b0);
    apply_stimulus("t4", 16'hAAAA, 8'd11, 0, 1'b0);
    apply_stimulus("t5", 16'h55D5, 8'd11, 1, 1'b1);

    // Reset lands on the second edge after accept, in the middle of conversion
    @(negedge clk);
    in_valid = 1'b1; z = 16'hAAAA; m = 8'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6.in_ready", 32'(in_ready), 32'd1);
    check("t6.out_valid", 32'(out_valid), 32'd0);
    check("t6.err", 32'(err), 32'd0);
    apply_stimulus("t6", 16'h5558, 8'd11, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) rz[2*i +: 2] = 2'($urandom_range(0, 2));
      rm = (t < 8) ? 8'($urandom_range(3, 40)) : 8'($urandom_range(100, 255));
      rm[0] = 1'b1;
      apply_stimulus("rand", rz, rm, $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
